imem_loader: RTL

//  Writer side of the instruction-memory interface: receives a program as a byte stream
//  (valid/ready), packs bytes big-endian into 32-bit MIPS words, writes them to INST_MEM at

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/word_packer.sv | 38 +++
 rtl/imem_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    BYTE,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_SHIFT     = 2;

endpackage

// File: rtl/word_packer.sv
// Packs a big-endian byte stream into 32-bit words and keeps a running XOR checksum.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic [7:0]  chk,
  output logic        word_ready
);

  logic [31:0] shreg;
  logic [1:0]  byte_cnt;

  // word_next already includes the incoming byte so the writer can latch the
  // completed word on the same edge that accepts the fourth byte.
  assign word_next  = {shreg[23:0], in_data};
  assign word_ready = shift && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      chk      <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      chk      <= '0;
    end else if (shift) begin
      shreg    <= word_next;
      chk      <= chk ^ in_data;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction memory and
// holds the CPU until a complete program with a good checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned size       = 32,
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  state_t      state, state_nxt;
  logic [7:0]  n_words;
  logic [7:0]  word_idx;
  logic        transfer;
  logic [31:0] word_next;
  logic [7:0]  chk;
  logic        word_ready;

  assign in_ready = (state == LEN) || (state == BYTE) || (state == CHK);
  assign transfer = in_valid && in_ready;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      ((state == LEN) && transfer),
    .shift      ((state == BYTE) && transfer),
    .in_data    (in_data),
    .word_next  (word_next),
    .chk        (chk),
    .word_ready (word_ready)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LEN:
        if (transfer) begin
          if (in_data == 8'd0)            state_nxt = DONE;
          else if (32'(in_data) > size)   state_nxt = ERR;
          else                            state_nxt = BYTE;
        end
      BYTE:
        if (word_ready) state_nxt = WRITE;
      WRITE:
        state_nxt = (word_idx == n_words - 8'd1) ? CHK : BYTE;
      CHK:
        if (transfer) state_nxt = (in_data == chk) ? DONE : ERR;
      DONE, ERR:
        if (start) state_nxt = LEN;
      default:
        state_nxt = LEN;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe instead of lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LEN;
      n_words  <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_en    <= (state_nxt == WRITE);
      done     <= (state_nxt == DONE);
      error    <= (state_nxt == ERR);
      cpu_hold <= (state_nxt != DONE);
      if ((state == LEN) && transfer) begin
        n_words  <= in_data;
        word_idx <= '0;
      end
      if (state == WRITE) word_idx <= word_idx + 8'd1;
      if (state_nxt == WRITE) begin
        wr_addr <= 32'(word_idx) << ADDR_SHIFT;
        wr_data <= word_next;
      end
    end
  end

endmodule
